round_key_store: RTL and testbench

- Consumer end of the round-key write interface driven by the key expansion block.
- Captures the 11 AES-128 round keys as they are presented with address 1..11, and tracks completeness.
- Replays the keys to the cipher datapath on request, one per beat, with a valid/ready handshake.
- Two replay orders: ascending (encrypt, key 1 first) and descending (decrypt, key 11 first).

---
 rtl/aes_key_pkg.sv | 43 ++++
 rtl/round_key_store_if.sv | 26 ++
 rtl/round_key_ram.sv | 45 ++++
 rtl/round_key_store.sv | 186 ++++++++++++++++++
 tb/tb_round_key_store.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared constants and types for the AES-128 round-key store.
//   NUM_KEYS / KEY_W / ADDR_W : store geometry (slot addresses 1..NUM_KEYS)
//   rd_state_e                : replay FSM state encoding
//   DIR_ENC / DIR_DEC         : replay direction (ascending / descending)
//   byte_parity()             : even parity per byte, used when
//                               ROUND_KEY_STORE_PARITY_EN is defined
package aes_key_pkg;

  localparam int unsigned NUM_KEYS  = 11;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned KEY_BYTES = KEY_W / 8;

  typedef logic [KEY_W-1:0]     key_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [KEY_BYTES-1:0] kpar_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam addr_t FIRST_ROUND = addr_t'(1);
  localparam addr_t LAST_ROUND  = addr_t'(NUM_KEYS);

  // Round at which a replay in the given direction ends.
  function automatic addr_t end_round(input logic dir);
    return (dir == DIR_DEC) ? FIRST_ROUND : LAST_ROUND;
  endfunction

  function automatic kpar_t byte_parity(input key_t k);
    kpar_t p;
    p = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      p[b] = ^k[b*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/round_key_store_if.sv
// round_key_store_if: replay beat channel from the key store to the cipher.
//   rk_data  : round key (KEY_W)
//   rk_round : round index 1..NUM_KEYS of rk_data
//   rk_valid : beat valid
//   rk_ready : consumer accepts when rk_valid & rk_ready
//   rk_last  : final beat of a replay
// Modports: master = key store, slave = cipher datapath.
interface round_key_store_if;
  import aes_key_pkg::*;

  key_t  rk_data;
  addr_t rk_round;
  logic  rk_valid;
  logic  rk_ready;
  logic  rk_last;

  modport master (
    output rk_data, rk_round, rk_valid, rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_data, rk_round, rk_valid, rk_last,
    output rk_ready
  );
endinterface

// File: rtl/round_key_ram.sv
// round_key_ram: NUM_KEYS x KEY_W register array, not reset.
//   clk      : write clock
//   we       : write enable
//   waddr    : write slot, 0-based
//   wdata    : write data
//   raddr    : read slot, 0-based (combinational read; out-of-range reads 0)
//   rdata    : read data
//   rpar_err : stored byte parity disagrees with rdata
//              (only with ROUND_KEY_STORE_PARITY_EN defined)
module round_key_ram
  import aes_key_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  key_t  wdata,
  input  addr_t raddr,
`ifdef ROUND_KEY_STORE_PARITY_EN
  output logic  rpar_err,
`endif
  output key_t  rdata
);

  key_t slot_q [NUM_KEYS];
  logic in_range;

  assign in_range = (raddr < LAST_ROUND);

  always_ff @(posedge clk) begin
    if (we) slot_q[waddr] <= wdata;
  end

  assign rdata = in_range ? slot_q[raddr] : '0;

`ifdef ROUND_KEY_STORE_PARITY_EN
  kpar_t par_q [NUM_KEYS];

  always_ff @(posedge clk) begin
    if (we) par_q[waddr] <= byte_parity(wdata);
  end

  assign rpar_err = in_range && (|(byte_parity(rdata) ^ par_q[raddr]));
`endif

endmodule

// File: rtl/round_key_store.sv
// round_key_store: captures the 11 AES-128 round keys from the expansion
// block and replays them to the cipher, ascending (encrypt) or descending
// (decrypt), one key per accepted beat.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_key      : round key from the expansion block
//   wr_addr     : slot 1..NUM_KEYS to write; 0 or out of range = no write;
//                 1 restarts the load (clears completeness)
//   wr_loaded   : expansion-done level
//   store_ready : every slot written since the last restart and wr_loaded seen
//   rd_start    : replay request pulse, rd_dir sampled with it (0 asc, 1 desc)
//   rd_err      : pulse, replay request rejected (store not ready)
//   rd_abort    : pulse, replay cancelled by a restart
//   rk          : replay beat channel (master side)
//   rk_par_err  : beat failed its byte-parity check
// Optional feature macro: ROUND_KEY_STORE_PARITY_EN (adds parity + rk_par_err).
module round_key_store
  import aes_key_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  key_t  wr_key,
  input  addr_t wr_addr,
  input  logic  wr_loaded,
  output logic  store_ready,
  input  logic  rd_start,
  input  logic  rd_dir,
  output logic  rd_err,
  output logic  rd_abort,
`ifdef ROUND_KEY_STORE_PARITY_EN
  output logic  rk_par_err,
`endif
  round_key_store_if.master rk
);

  // ---------------- write side ----------------
  logic                wr_hit;
  logic                restart;
  addr_t               wr_slot;
  logic [NUM_KEYS-1:0] bitmap_q;
  logic                store_ready_q;

  assign wr_hit  = (wr_addr != '0) && (wr_addr <= LAST_ROUND);
  assign restart = (wr_addr == FIRST_ROUND);
  assign wr_slot = wr_addr - FIRST_ROUND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q      <= '0;
      store_ready_q <= 1'b0;
    end else begin
      if (restart)     bitmap_q <= {{(NUM_KEYS-1){1'b0}}, 1'b1};
      else if (wr_hit) bitmap_q[wr_slot] <= 1'b1;

      if (restart)                       store_ready_q <= 1'b0;
      else if (&bitmap_q && wr_loaded)   store_ready_q <= 1'b1;
    end
  end

  assign store_ready = store_ready_q;

  // ---------------- key array ----------------
  addr_t rd_slot;
  key_t  rd_key;
`ifdef ROUND_KEY_STORE_PARITY_EN
  logic  rd_par_err;
`endif

  round_key_ram u_ram (
    .clk      (clk),
    .we       (wr_hit),
    .waddr    (wr_slot),
    .wdata    (wr_key),
    .raddr    (rd_slot),
`ifdef ROUND_KEY_STORE_PARITY_EN
    .rpar_err (rd_par_err),
`endif
    .rdata    (rd_key)
  );

  // ---------------- replay FSM ----------------
  rd_state_e state_q, state_n;
  logic      dir_q, dir_n;
  addr_t     round_q, round_n;
  logic      valid_q, valid_n;
  logic      last_q, last_n;
  logic      err_n, abort_n;
  logic      err_q, abort_q;
  logic      load;
  key_t      data_q;

  // The array is read at the index the beat register will hold next, so the
  // key is captured in the same edge as the index; a write to the slot being
  // presented therefore only shows at the next advance.
  assign rd_slot = round_n - FIRST_ROUND;

  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    round_n = round_q;
    valid_n = valid_q;
    last_n  = last_q;
    err_n   = 1'b0;
    abort_n = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          // a restart in the same cycle invalidates the store
          if (store_ready_q && !restart) begin
            state_n = RUN;
            dir_n   = rd_dir;
            round_n = (rd_dir == DIR_DEC) ? LAST_ROUND : FIRST_ROUND;
            valid_n = 1'b1;
            last_n  = (round_n == end_round(rd_dir));
            load    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (restart) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          abort_n = 1'b1;
        end else if (valid_q && rk.rk_ready) begin
          if (last_q) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            round_n = (dir_q == DIR_DEC) ? (round_q - FIRST_ROUND)
                                         : (round_q + FIRST_ROUND);
            last_n  = (round_n == end_round(dir_q));
            load    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_ENC;
      round_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      round_q <= round_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      err_q   <= err_n;
      abort_q <= abort_n;
      if (load) data_q <= rd_key;
    end
  end

`ifdef ROUND_KEY_STORE_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        par_err_q <= 1'b0;
    else if (load)     par_err_q <= rd_par_err;
    else if (!valid_n) par_err_q <= 1'b0;
  end

  assign rk_par_err = par_err_q;
`endif

  assign rk.rk_data  = data_q;
  assign rk.rk_round = round_q;
  assign rk.rk_valid = valid_q;
  assign rk.rk_last  = last_q;
  assign rd_err      = err_q;
  assign rd_abort    = abort_q;

endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed bench for round_key_store.
// Define ROUND_KEY_STORE_PARITY_EN to also exercise the parity output.
module tb_round_key_store;
  import aes_key_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  key_t  wr_key;
  addr_t wr_addr;
  logic  wr_loaded;
  logic  store_ready;
  logic  rd_start;
  logic  rd_dir;
  logic  rd_err;
  logic  rd_abort;
`ifdef ROUND_KEY_STORE_PARITY_EN
  logic        rk_par_err;
  int unsigned bad_round = 0;
`endif

  round_key_store_if rk_bus ();

  round_key_store u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_key      (wr_key),
    .wr_addr     (wr_addr),
    .wr_loaded   (wr_loaded),
    .store_ready (store_ready),
    .rd_start    (rd_start),
    .rd_dir      (rd_dir),
    .rd_err      (rd_err),
    .rd_abort    (rd_abort),
`ifdef ROUND_KEY_STORE_PARITY_EN
    .rk_par_err  (rk_par_err),
`endif
    .rk          (rk_bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  key_t        exp_key [1:NUM_KEYS];

  task automatic check(input string tag, input key_t got, input key_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slots(input int unsigned first);
    for (int unsigned a = first; a <= NUM_KEYS; a++) begin
      wr_addr = addr_t'(a);
      wr_key  = exp_key[a];
      tick();
    end
    wr_addr = '0;
  endtask

  // Full replay with rk_ready held high; checks every beat against exp_key.
  task automatic replay(input logic dir);
    int unsigned r;
    rd_start = 1'b1;
    rd_dir   = dir;
    rk_bus.rk_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int unsigned b = 0; b < NUM_KEYS; b++) begin
      r = dir ? (NUM_KEYS - b) : (b + 1);
      check("rp_valid", key_t'(rk_bus.rk_valid), key_t'(1));
      check("rp_round", key_t'(rk_bus.rk_round), key_t'(r));
      check("rp_data",  rk_bus.rk_data, exp_key[r]);
      check("rp_last",  key_t'(rk_bus.rk_last), key_t'(b == NUM_KEYS - 1));
`ifdef ROUND_KEY_STORE_PARITY_EN
      check("rp_par_err", key_t'(rk_par_err), key_t'(r == bad_round));
`endif
      tick();
    end
    check("rp_valid_end", key_t'(rk_bus.rk_valid), key_t'(0));
    check("rp_last_end",  key_t'(rk_bus.rk_last), key_t'(0));
  endtask

  initial begin
    int unsigned idx;
    int unsigned accepts;
    int unsigned cyc;
    logic [3:0]  pat;

    rst_n = 1'b0;
    wr_key = '0;
    wr_addr = '0;
    wr_loaded = 1'b0;
    rd_start = 1'b0;
    rd_dir = 1'b0;
    rk_bus.rk_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset state
    check("rst_valid", key_t'(rk_bus.rk_valid), key_t'(0));
    check("rst_last",  key_t'(rk_bus.rk_last), key_t'(0));
    check("rst_round", key_t'(rk_bus.rk_round), key_t'(0));
    check("rst_data",  rk_bus.rk_data, key_t'(0));
    check("rst_ready", key_t'(store_ready), key_t'(0));
    check("rst_err",   key_t'(rd_err), key_t'(0));
    check("rst_abort", key_t'(rd_abort), key_t'(0));

    // replay request before any load is rejected
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("early_err",   key_t'(rd_err), key_t'(1));
    check("early_valid", key_t'(rk_bus.rk_valid), key_t'(0));
    tick();
    check("early_err_pulse", key_t'(rd_err), key_t'(0));
    check("early_valid2",    key_t'(rk_bus.rk_valid), key_t'(0));

    // load 1..11, then out-of-range addresses must not disturb anything
    for (int unsigned a = 1; a <= NUM_KEYS; a++) exp_key[a] = key_t'(a);
    write_slots(1);
    check("load_ready_no_loaded", key_t'(store_ready), key_t'(0));
    wr_addr = addr_t'(12); wr_key = '1; tick();
    wr_addr = addr_t'(15); tick();
    wr_addr = '0;
    check("oor_ready", key_t'(store_ready), key_t'(0));
    wr_loaded = 1'b1;
    tick();
    check("load_ready", key_t'(store_ready), key_t'(1));

    replay(DIR_ENC);
    replay(DIR_DEC);

    // stalls 1,0,0,1 during an ascending replay; rd_start mid-run ignored
    pat = 4'b1001;
    idx = 1;
    accepts = 0;
    cyc = 0;
    rd_start = 1'b1;
    rd_dir = DIR_ENC;
    tick();
    rd_start = 1'b0;
    while (accepts < NUM_KEYS && cyc < 100) begin
      rk_bus.rk_ready = pat[cyc % 4];
      if (cyc == 2) begin
        rd_start = 1'b1;
        rd_dir   = DIR_DEC;
      end else begin
        rd_start = 1'b0;
      end
      check("st_valid", key_t'(rk_bus.rk_valid), key_t'(1));
      check("st_round", key_t'(rk_bus.rk_round), key_t'(idx));
      check("st_data",  rk_bus.rk_data, exp_key[idx]);
      check("st_last",  key_t'(rk_bus.rk_last), key_t'(idx == NUM_KEYS));
      check("st_no_err", key_t'(rd_err), key_t'(0));
      tick();
      if (rk_bus.rk_ready) begin
        accepts++;
        idx++;
      end
      cyc++;
    end
    rd_start = 1'b0;
    check("st_accepts",  key_t'(accepts), key_t'(NUM_KEYS));
    check("st_valid_end", key_t'(rk_bus.rk_valid), key_t'(0));

    // restart after round 4 accepted aborts the replay
    rk_bus.rk_ready = 1'b1;
    rd_start = 1'b1;
    rd_dir = DIR_ENC;
    tick();
    rd_start = 1'b0;
    repeat (4) tick();
    check("ab_round5", key_t'(rk_bus.rk_round), key_t'(5));
    rk_bus.rk_ready = 1'b0;
    exp_key[1] = key_t'(128'hA5);
    wr_addr = FIRST_ROUND;
    wr_key = exp_key[1];
    tick();
    wr_addr = '0;
    check("ab_abort", key_t'(rd_abort), key_t'(1));
    check("ab_valid", key_t'(rk_bus.rk_valid), key_t'(0));
    check("ab_last",  key_t'(rk_bus.rk_last), key_t'(0));
    check("ab_ready", key_t'(store_ready), key_t'(0));
    tick();
    check("ab_abort_pulse", key_t'(rd_abort), key_t'(0));
    check("ab_ready2", key_t'(store_ready), key_t'(0));
    write_slots(2);
    check("ab_ready_reload", key_t'(store_ready), key_t'(0));
    tick();
    check("ab_ready_back", key_t'(store_ready), key_t'(1));

    // rd_start together with a restart is rejected
    rd_start = 1'b1;
    wr_addr = FIRST_ROUND;
    wr_key = exp_key[1];
    tick();
    rd_start = 1'b0;
    wr_addr = '0;
    check("rs_err",   key_t'(rd_err), key_t'(1));
    check("rs_valid", key_t'(rk_bus.rk_valid), key_t'(0));
    check("rs_ready", key_t'(store_ready), key_t'(0));
    write_slots(2);
    tick();
    check("rs_ready_back", key_t'(store_ready), key_t'(1));

`ifdef ROUND_KEY_STORE_PARITY_EN
    u_dut.u_ram.slot_q[4] = u_dut.u_ram.slot_q[4] ^ key_t'(8);
    exp_key[5] = exp_key[5] ^ key_t'(8);
    bad_round = 5;
`endif
    replay(DIR_DEC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
